// File: rtl/relu_maxpool2.sv
// relu_maxpool2: ReLU followed by 2x2 stride-2 max pooling on a raster pixel stream.
// Each beat carries CH signed channels. Odd trailing rows and columns are dropped (floor pooling).
// Optional macro RELU_MAXPOOL2_RELU_EN: when defined, negative inputs are clamped to 0 before pooling.
// When it is undefined, raw signed values are pooled.
module relu_maxpool2 #(
   parameter int IN_W      = 13,
   parameter int IN_H      = 17,
   parameter int CH        = 64,
   parameter int DATA_BITS = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic                    sof_in,
   input  logic [CH*DATA_BITS-1:0] data_in,
   output logic                    valid_out,
   output logic [CH*DATA_BITS-1:0] data_out,
   output logic [3:0]              out_col,
   output logic [3:0]              out_row,
   output logic                    frame_done
);

   localparam int PW = IN_W / 2;
   localparam int PH = IN_H / 2;
   localparam int CW = $clog2(IN_W);
   localparam int RW = $clog2(IN_H);
   localparam int LW = (PW > 1) ? $clog2(PW) : 1;

   localparam logic [1:0] S_TOP  = 2'd0;
   localparam logic [1:0] S_BOT  = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   typedef logic [CH-1:0][DATA_BITS-1:0] vec_t;

   logic [CW-1:0] col_q, col_d, col_e;
   logic [RW-1:0] row_q, row_d, row_e;
   logic [1:0]    state_q, state_d, st_e;

   vec_t          hold_q;
   vec_t          lb_q [PW];
   vec_t          x_v, r_v, pair_max, win_max;

   logic          odd_col, in_cols, end_row, end_frame, out_fire, out_last;
   logic [LW-1:0] lb_idx;

   function automatic logic [DATA_BITS-1:0] smax(input logic [DATA_BITS-1:0] a,
                                                 input logic [DATA_BITS-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   // Effective position and state for this beat (sof overrides), plus next-state counters and FSM.
   always_comb begin
      col_e     = sof_in ? '0 : col_q;
      row_e     = sof_in ? '0 : row_q;
      st_e      = sof_in ? S_TOP : state_q;
      odd_col   = col_e[0];
      in_cols   = (32'(col_e) < 32'(2 * PW));
      lb_idx    = LW'(col_e >> 1);
      end_row   = (32'(col_e) == 32'(IN_W - 1));
      end_frame = end_row && (32'(row_e) == 32'(IN_H - 1));
      out_fire  = valid_in && (st_e == S_BOT) && odd_col && in_cols;
      out_last  = (32'(row_e >> 1) == 32'(PH - 1)) && (32'(col_e >> 1) == 32'(PW - 1));
      col_d     = col_q;
      row_d     = row_q;
      state_d   = state_q;
      if (valid_in) begin
         col_d   = end_row ? '0 : col_e + 1'b1;
         row_d   = end_frame ? '0 : (end_row ? row_e + 1'b1 : row_e);
         state_d = st_e;
         if (end_row) begin
            case (st_e)
               S_TOP:   state_d = S_BOT;
               // A trailing odd row has no partner, so it is consumed without effect.
               S_BOT:   state_d = ((IN_H % 2 == 1) && (32'(row_e) + 1 == 32'(IN_H - 1))) ? S_DROP : S_TOP;
               default: state_d = S_TOP;
            endcase
         end
      end
   end

   // Per-channel ReLU (optional), the horizontal pair max, and the full 2x2 window max.
   always_comb begin
      x_v = vec_t'(data_in);
      for (int k = 0; k < CH; k++) begin
`ifdef RELU_MAXPOOL2_RELU_EN
         r_v[k] = x_v[k][DATA_BITS-1] ? '0 : x_v[k];
`else
         r_v[k] = x_v[k];
`endif
         pair_max[k] = smax(hold_q[k], r_v[k]);
         win_max[k]  = smax(lb_q[lb_idx][k], pair_max[k]);
      end
   end

   // Datapath storage: the hold register and the line buffer of top-row pair maxima. Neither is reset.
   always_ff @(posedge clk) begin
      if (valid_in && in_cols) begin
         if (!odd_col && (st_e != S_DROP)) hold_q <= r_v;
         if (odd_col && (st_e == S_TOP))   lb_q[lb_idx] <= pair_max;
      end
   end

   // Position counters, FSM, and registered outputs. The data outputs hold their value between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q      <= '0;
         row_q      <= '0;
         state_q    <= S_TOP;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         data_out   <= '0;
         out_col    <= '0;
         out_row    <= '0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         state_q    <= state_d;
         valid_out  <= out_fire;
         frame_done <= out_fire && out_last;
         if (out_fire) begin
            data_out <= win_max;
            out_col  <= 4'(col_e >> 1);
            out_row  <= 4'(row_e >> 1);
         end
      end
   end

endmodule

// File: doc/relu_maxpool2.md
Name: relu_maxpool2

Overview:
- Stage directly downstream of the conv2 layer.
- Consumes the conv2 result stream: one channel-parallel pixel vector of 64 signed 32-bit values per valid beat, in raster order.
- Applies ReLU, then 2x2 stride-2 max pooling per channel.
- Emits the pooled feature map, also in raster order, to the next layer.

Parameters:
- IN_W, 13, input feature-map width in pixels (conv2 output width).
- IN_H, 17, input feature-map height in pixels.
- CH, 64, channels per pixel vector.
- DATA_BITS, 32, signed two's-complement width per channel.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- valid_in  input  1  data_in holds a valid pixel this cycle.
- sof_in  input  1  qualified by valid_in; this pixel is (row 0, col 0).
- data_in  input  CH*DATA_BITS  pixel vector; channel k occupies bits [k*DATA_BITS +: DATA_BITS].
- valid_out  output  1  one-cycle pulse; data_out is valid.
- data_out  output  CH*DATA_BITS  pooled pixel vector, same packing as data_in.
- out_col  output  4  pooled column index, 0..IN_W/2-1.
- out_row  output  4  pooled row index, 0..IN_H/2-1.
- frame_done  output  1  one-cycle pulse, coincident with the last valid_out of a frame.

Behaviour:
- Reset (async, rst_n=0): every output is 0; col/row counters are 0; FSM is S_TOP; line buffer and hold register contents are don't-care.
  - Reset mid-frame discards the partial frame; the next valid_in is pixel (0,0).
- Flow control: no backpressure. valid_in may be asserted on consecutive cycles or with arbitrary gaps. No state changes on cycles with valid_in=0.
- ReLU per channel: r = (x[DATA_BITS-1]) ? 0 : x. Max is a signed compare at DATA_BITS; there is no width growth.
- Counters: col 0..IN_W-1 and row 0..IN_H-1 advance on each valid_in. col wraps to 0 and row increments at col=IN_W-1. Both wrap to 0 after pixel (IN_H-1, IN_W-1).
- sof_in=1 with valid_in:
  - Forces this pixel to be treated as (0,0) and the FSM to S_TOP, regardless of current counters.
  - The aborted frame produces no further outputs and no frame_done.
- Odd dimensions use floor pooling:
  - Column IN_W-1 is ignored when IN_W is odd.
  - Row IN_H-1 is ignored when IN_H is odd.
  - Defaults give a 6x8 output, 48 valid_out pulses per frame.
- FSM:
  - S_TOP (even row):
    - Even col: store r in hold register.
    - Odd col: write max(hold, r) into line buffer entry col/2.
    - At end of row: go to S_BOT.
  - S_BOT (odd row):
    - Even col: hold = r.
    - Odd col: result = max(linebuf[col/2], hold, r).
    - At end of row: go to S_TOP, or to S_DROP if the next row is IN_H-1 and IN_H is odd.
  - S_DROP: consume the row with no writes and no outputs; go to S_TOP at frame end.
- Line buffer: IN_W/2 entries of CH*DATA_BITS.
- Latency: valid_out, data_out, out_col and out_row are registered. They assert exactly 1 cycle after the valid_in beat of the bottom-right pixel of each 2x2 window.
- data_out, out_col and out_row hold their value until the next valid_out.
- frame_done pulses with the valid_out for pooled pixel (IN_H/2-1, IN_W/2-1).
- Simultaneous events: sof_in on the same beat that would complete a window suppresses that window's output.

Optional Feature:
- Macro: RELU_MAXPOOL2_RELU_EN.
- Defined: ReLU is applied before pooling, as above; data_out is never negative.
- Undefined: ReLU stage removed; plain signed max pooling of raw inputs. Negative maxima pass through unchanged. Timing is identical.

Test Plan:
- Ramp frame: channel k of pixel (r,c) = r*16+c+k, with sof_in on the first beat, continuous valid_in.
  -> 48 valid_out pulses.
  -> First pulse: out_row=0, out_col=0, ch0 = 17, arriving 1 cycle after input pixel (1,1).
  -> frame_done coincides with out_row=7, out_col=5, ch0 = 15*16+11 = 251.
- All inputs = -5 (0xFFFFFFFB).
  -> With RELU_MAXPOOL2_RELU_EN, every output channel = 0.
  -> Without it, every output channel = 0xFFFFFFFB.
- Mixed window: ch3 = {0x7FFFFFFF, 0x80000000, 1, -1} at positions (0,0),(0,1),(1,0),(1,1).
  -> ch3 out = 0x7FFFFFFF, which checks the signed compare.
- Gapped input: random 0–5 idle cycles between beats of the ramp frame.
  -> Outputs are identical to the ramp-frame case, each still 1 cycle after its triggering beat.
- Abort: send 40 pixels, then sof_in on a new frame.
  -> No frame_done for the aborted frame; the new frame yields 48 correct outputs.
  -> Repeat with rst_n pulsed low at pixel 100 instead: all outputs read 0 during reset, and the next frame is correct.
- Odd edges: put the value 1000 only in column 12 and row 16.
  -> No output ever equals 1000; the pulse count stays 48 per frame.
